// File: rtl/bidir_bus_port.sv
// Half-duplex tri-state bus port: drives the pad for one cycle per write, then holds it
// released for TURN_CYC cycles; samples the bus on reads. Define BIDIR_BUS_SYNC_EN to add
// a 2-flop synchronizer in front of read capture (3-cycle SAMPLE).
module bidir_bus_port #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned TURN_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  input  logic             rd_req,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  inout  wire  [WIDTH-1:0] bus_io,
  output logic             bus_oe,
  output logic             busy
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StDrive  = 2'd1;
  localparam logic [1:0] StTurn   = 2'd2;
  localparam logic [1:0] StSample = 2'd3;

  localparam logic [3:0] TurnLoad = 4'(TURN_CYC - 1);

  logic [1:0]       state_q, state_d;
  logic             oe_q, oe_d;
  logic [WIDTH-1:0] wr_latch_q, wr_latch_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] sample_val;

`ifdef BIDIR_BUS_SYNC_EN
  // Counter value loaded on entry to SAMPLE; SAMPLE lasts SampleLast+1 cycles.
  localparam logic [3:0] SampleLast = 4'd2;

  logic [WIDTH-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus_io;
      sync2_q <= sync1_q;
    end
  end

  assign sample_val = sync2_q;
`else
  localparam logic [3:0] SampleLast = 4'd0;

  assign sample_val = bus_io;
`endif

  always_comb begin
    state_d    = state_q;
    oe_d       = oe_q;
    wr_latch_d = wr_latch_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    cnt_d      = cnt_q;
    case (state_q)
      StIdle: begin
        // Write wins a tie; rd_req is a level so the read is retried after turnaround.
        if (wr_valid) begin
          wr_latch_d = wr_data;
          oe_d       = 1'b1;
          state_d    = StDrive;
        end else if (rd_req) begin
          cnt_d   = SampleLast;
          state_d = StSample;
        end
      end
      StDrive: begin
        oe_d    = 1'b0;
        cnt_d   = TurnLoad;
        state_d = StTurn;
      end
      StTurn: begin
        if (cnt_q == 4'd0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StSample: begin
        if (cnt_q == 4'd0) begin
          rd_data_d  = sample_val;
          rd_valid_d = 1'b1;
          state_d    = StIdle;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        oe_d    = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      oe_q       <= 1'b0;
      wr_latch_q <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      cnt_q      <= 4'd0;
    end else begin
      state_q    <= state_d;
      oe_q       <= oe_d;
      wr_latch_q <= wr_latch_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus_io   = oe_q ? wr_latch_q : {WIDTH{1'bz}};
  assign bus_oe   = oe_q;
  assign wr_ready = (state_q == StIdle);
  assign busy     = (state_q != StIdle);
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_bidir_bus_port.sv
// Scoreboard bench for bidir_bus_port: stimulus pushes expected bus/read values, a negedge
// monitor pops and compares whenever bus_oe or rd_valid is seen.
module tb_bidir_bus_port;

  localparam int W  = 8;
  localparam int TC = 2;
`ifdef BIDIR_BUS_SYNC_EN
  localparam int RdLat = 4;
`else
  localparam int RdLat = 2;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         wr_valid = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic         rd_req = 1'b0;
  logic         wr_ready, rd_valid, bus_oe, busy;
  logic [W-1:0] rd_data;
  wire  [W-1:0] bus_io;
  logic         peer_en = 1'b0;
  logic [W-1:0] peer_val = '0;

  assign bus_io = peer_en ? peer_val : {W{1'bz}};

  always #5 clk = ~clk;

  bidir_bus_port #(.WIDTH(W), .TURN_CYC(TC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .rd_req   (rd_req),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .bus_io   (bus_io),
    .bus_oe   (bus_oe),
    .busy     (busy)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] rd_q[$];
  logic [W-1:0] wr_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // With the DUT released, a peer-driven probe value must appear unaltered on the bus.
  task automatic probe_released(input string name);
    logic         save_en;
    logic [W-1:0] save_val;
    save_en  = peer_en;
    save_val = peer_val;
    peer_val = 8'h69;
    peer_en  = 1'b1;
    #1;
    check({name, "_oe"}, 32'(bus_oe), 32'd0);
    check({name, "_bus"}, 32'(bus_io), 32'h69);
    peer_val = save_val;
    peer_en  = save_en;
  endtask

  task automatic wait_rd_valid(input string name, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!rd_valid && n < 20);
    if (!rd_valid) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_valid) begin
        if (rd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_unexpected: got rd_valid=1 data %0h expected no read", rd_data);
        end else begin
          check("rd_data", 32'(rd_data), 32'(rd_q.pop_front()));
        end
      end
      if (bus_oe) begin
        if (wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_unexpected: got bus_oe=1 bus %0h expected released", bus_io);
        end else begin
          check("wr_bus", 32'(bus_io), 32'(wr_q.pop_front()));
        end
      end
      if (peer_en) check("no_contention", 32'(bus_oe), 32'd0);
    end
  end

  initial begin
    int n;
    logic [W-1:0] rd_vals[2];
    rd_vals[0] = 8'h3C;
    rd_vals[1] = 8'hC3;

    // Reset with both requests asserted
    rst_n    = 1'b0;
    wr_valid = 1'b1;
    wr_data  = 8'hFF;
    rd_req   = 1'b1;
    repeat (2) tick();
    check("rst_oe", 32'(bus_oe), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    probe_released("rst_release");
    wr_valid = 1'b0;
    rd_req   = 1'b0;
    rst_n    = 1'b1;
    tick();
    check("post_rst_wr_ready", 32'(wr_ready), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);

    // Single write of A5; later wr_data changes while busy must be ignored
    wr_data  = 8'hA5;
    wr_valid = 1'b1;
    wr_q.push_back(8'hA5);
    tick();
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    check("wr_drive_oe", 32'(bus_oe), 32'd1);
    check("wr_drive_bus", 32'(bus_io), 32'hA5);
    check("wr_drive_ready", 32'(wr_ready), 32'd0);
    check("wr_drive_busy", 32'(busy), 32'd1);
    for (int i = 0; i < TC; i++) begin
      tick();
      check("wr_turn_ready", 32'(wr_ready), 32'd0);
      probe_released("wr_turn");
    end
    tick();
    check("wr_done_ready", 32'(wr_ready), 32'd1);
    check("wr_done_busy", 32'(busy), 32'd0);

    // Single pulsed reads, peer driving the bus
    for (int i = 0; i < 2; i++) begin
      peer_val = rd_vals[i];
      peer_en  = 1'b1;
      rd_req   = 1'b1;
      rd_q.push_back(rd_vals[i]);
      tick();
      rd_req = 1'b0;
      check("rd_accept_busy", 32'(busy), 32'd1);
      n = 1;
      while (!rd_valid && n < 20) begin
        tick();
        n++;
      end
      check("rd_latency", 32'(n), 32'(RdLat));
      tick();
      check("rd_valid_pulse", 32'(rd_valid), 32'd0);
      check("rd_idle_after", 32'(busy), 32'd0);
      peer_en = 1'b0;
    end

    // Simultaneous write (11) and held read: write first, read after turnaround
    wr_data  = 8'h11;
    wr_valid = 1'b1;
    rd_req   = 1'b1;
    wr_q.push_back(8'h11);
    tick();
    wr_valid = 1'b0;
    check("sim_write_first", 32'(bus_oe), 32'd1);
    n = 0;
    while (!wr_ready && n < 20) begin
      check("sim_no_early_rd", 32'(rd_valid), 32'd0);
      tick();
      n++;
    end
    check("sim_turn_len", 32'(n), 32'(TC + 1));
    peer_val = 8'hE7;
    peer_en  = 1'b1;
    rd_q.push_back(8'hE7);
    wait_rd_valid("sim_rd", n);
    check("sim_rd_latency", 32'(n), 32'(RdLat));
    rd_req = 1'b0;
    tick();
    check("sim_rd_pulse", 32'(rd_valid), 32'd0);
    peer_en = 1'b0;

    // Back-to-back reads with rd_req held
    peer_val = 8'h5A;
    peer_en  = 1'b1;
    rd_req   = 1'b1;
    rd_q.push_back(8'h5A);
    rd_q.push_back(8'h5A);
    wait_rd_valid("b2b_first", n);
    check("b2b_first_latency", 32'(n), 32'(RdLat));
    wait_rd_valid("b2b_second", n);
    check("b2b_spacing", 32'(n), 32'(RdLat));
    rd_req = 1'b0;
    tick();
    check("b2b_end_pulse", 32'(rd_valid), 32'd0);
    peer_en = 1'b0;

    // Reset asserted during DRIVE
    wr_data  = 8'hC0;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    check("mid_rst_drive", 32'(bus_oe), 32'd1);
    wr_q.delete();
    rst_n = 1'b0;
    #1;
    check("mid_rst_oe_async", 32'(bus_oe), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    probe_released("mid_rst");
    tick();
    rst_n = 1'b1;
    tick();
    check("mid_rst_idle_ready", 32'(wr_ready), 32'd1);
    check("mid_rst_idle_busy", 32'(busy), 32'd0);
    check("mid_rst_idle_oe", 32'(bus_oe), 32'd0);
    repeat (3) tick();

    check("rd_q_drained", 32'(rd_q.size()), 32'd0);
    check("wr_q_drained", 32'(wr_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
